// File: rtl/vx_ahb_pkg.sv
// Shared types for the Vortex-to-AHB request queue: issue-state encoding and queued request entry.
package vx_ahb_pkg;

  localparam int LINE_BYTES    = 64;
  localparam int VX_DATA_WIDTH = LINE_BYTES * 8;
  localparam int VX_ADDR_WIDTH = 26;
  localparam int VX_TAG_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RESP
  } issue_state_e;

  typedef struct packed {
    logic                     rw;
    logic [VX_ADDR_WIDTH-1:0] addr;
    logic [VX_DATA_WIDTH-1:0] data;
    logic [VX_TAG_WIDTH-1:0]  tag;
  } req_entry_t;

endpackage

// File: rtl/vx_ahb_req_fifo.sv
// Synchronous FIFO of request entries; head is visible combinationally, full/empty come from the count register.
// Push while full and pop while empty are ignored; simultaneous push and pop are both honoured.
module vx_ahb_req_fifo
  import vx_ahb_pkg::*;
#(
  parameter type entry_t = req_entry_t,
  parameter int  DEPTH   = 4,
  parameter int  CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  entry_t           push_dat_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok;
  logic               pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/vx_ahb_req_queue.sv
// Buffers Vortex line requests and issues them one at a time to the single-outstanding AHB adapter,
// re-attaching the tag to read responses and swallowing write completions.
module vx_ahb_req_queue
  import vx_ahb_pkg::*;
#(
  parameter int DATA_WIDTH   = LINE_BYTES * 8,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_WIDTH    = 8,
  parameter int BYTEEN_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    up_req_valid,
  input  logic                    up_req_rw,
  input  logic [BYTEEN_WIDTH-1:0] up_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   up_req_addr,
  input  logic [DATA_WIDTH-1:0]   up_req_data,
  input  logic [TAG_WIDTH-1:0]    up_req_tag,
  output logic                    up_req_ready,

  output logic                    up_rsp_valid,
  output logic [DATA_WIDTH-1:0]   up_rsp_data,
  output logic [TAG_WIDTH-1:0]    up_rsp_tag,
  input  logic                    up_rsp_ready,

  output logic                    dn_req_valid,
  output logic                    dn_req_rw,
  output logic [ADDR_WIDTH-1:0]   dn_req_addr,
  output logic [DATA_WIDTH-1:0]   dn_req_data,
  input  logic                    dn_req_ready,

  input  logic                    dn_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   dn_rsp_data,
  output logic                    dn_rsp_ready,

  output logic                    partial_wr,
  output logic                    busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Same layout as req_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } entry_t;

  issue_state_e          state_q, state_d;
  logic                  cur_rw_q;
  logic [TAG_WIDTH-1:0]  cur_tag_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic                  partial_q;

  entry_t                push_dat;
  entry_t                head;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_avail;
  logic                  rd_capture;

  assign up_req_ready = !fifo_full;
  assign fifo_push    = up_req_valid && up_req_ready;
  assign push_dat     = '{rw: up_req_rw, addr: up_req_addr, data: up_req_data, tag: up_req_tag};

  vx_ahb_req_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (fifo_push),
    .push_dat_i (push_dat),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // Only ISSUE pops, so elsewhere "non-empty after this cycle" is just occupancy or an incoming push.
  assign fifo_avail = !fifo_empty || fifo_push;

  assign dn_req_rw   = head.rw;
  assign dn_req_addr = head.addr;
  assign dn_req_data = head.data;

  always_comb begin
    state_d      = state_q;
    dn_req_valid = 1'b0;
    dn_rsp_ready = 1'b0;
    up_rsp_valid = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_avail) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        dn_req_valid = 1'b1;
        if (dn_req_ready) begin
          fifo_pop = 1'b1;
          state_d  = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        dn_rsp_ready = 1'b1;
        if (dn_rsp_valid) begin
          if (cur_rw_q) state_d = fifo_avail ? ST_ISSUE : ST_IDLE;
          else          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        up_rsp_valid = 1'b1;
        if (up_rsp_ready) state_d = fifo_avail ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign rd_capture = (state_q == ST_WAIT_RSP) && dn_rsp_valid && !cur_rw_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_rw_q   <= 1'b0;
      cur_tag_q  <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      partial_q  <= 1'b0;
    end else begin
      if (fifo_pop) begin
        cur_rw_q  <= head.rw;
        cur_tag_q <= head.tag;
      end
      if (rd_capture) begin
        rsp_data_q <= dn_rsp_data;
        rsp_tag_q  <= cur_tag_q;
      end
      // The full line is still forwarded; this flag just records that masked bytes were overwritten.
      if (fifo_push && up_req_rw && !(&up_req_byteen)) partial_q <= 1'b1;
    end
  end

  assign up_rsp_data = rsp_data_q;
  assign up_rsp_tag  = rsp_tag_q;
  assign partial_wr  = partial_q;
  assign busy        = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_vx_ahb_req_queue.sv
// Randomized bench for vx_ahb_req_queue against a transaction-level queue model of the request path.
module tb_vx_ahb_req_queue;

  localparam int DW = 512, AW = 26, TW = 8, BW = DW / 8, DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          up_req_valid, up_req_rw, up_req_ready;
  logic [BW-1:0] up_req_byteen;
  logic [AW-1:0] up_req_addr;
  logic [DW-1:0] up_req_data;
  logic [TW-1:0] up_req_tag;
  logic          up_rsp_valid, up_rsp_ready;
  logic [DW-1:0] up_rsp_data;
  logic [TW-1:0] up_rsp_tag;
  logic          dn_req_valid, dn_req_rw, dn_req_ready;
  logic [AW-1:0] dn_req_addr;
  logic [DW-1:0] dn_req_data;
  logic          dn_rsp_valid, dn_rsp_ready;
  logic [DW-1:0] dn_rsp_data;
  logic          partial_wr, busy;

  always #5 clk = ~clk;

  vx_ahb_req_queue dut (
    .clk(clk), .reset(reset),
    .up_req_valid(up_req_valid), .up_req_rw(up_req_rw), .up_req_byteen(up_req_byteen),
    .up_req_addr(up_req_addr), .up_req_data(up_req_data), .up_req_tag(up_req_tag),
    .up_req_ready(up_req_ready),
    .up_rsp_valid(up_rsp_valid), .up_rsp_data(up_rsp_data), .up_rsp_tag(up_rsp_tag),
    .up_rsp_ready(up_rsp_ready),
    .dn_req_valid(dn_req_valid), .dn_req_rw(dn_req_rw), .dn_req_addr(dn_req_addr),
    .dn_req_data(dn_req_data), .dn_req_ready(dn_req_ready),
    .dn_rsp_valid(dn_rsp_valid), .dn_rsp_data(dn_rsp_data), .dn_rsp_ready(dn_rsp_ready),
    .partial_wr(partial_wr), .busy(busy)
  );

  typedef struct {
    logic          rw;
    logic [BW-1:0] byteen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } rsp_t;

  // Model: stim_q = not yet offered, req_q = accepted but not issued, cur = the one in flight.
  req_t stim_q[$];
  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t cur;
  bit   inflight, resp_pending, partial_exp;
  int   delay;

  int   p_req, p_dnrdy, p_rsprdy, p_spur, fix_delay;
  bit   use_fix_data;
  logic [DW-1:0] fix_data;

  int   n_chk, n_bad;
  int   dn_hs_cnt, up_hs_cnt, wr_done_cnt;
  logic [TW-1:0] tag_log[$];
  logic [DW-1:0] last_rsp_data;
  logic [TW-1:0] last_rsp_tag;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic req_t mk_req(input logic rw, input logic [AW-1:0] addr,
                                  input logic [TW-1:0] tag, input logic [BW-1:0] be);
    req_t r;
    r.rw = rw; r.addr = addr; r.tag = tag; r.byteen = be; r.data = rand_line();
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [BW-1:0] be;
    be = '1;
    if ($urandom_range(9) == 0) be[$urandom_range(BW-1)] = 1'b0;
    return mk_req(1'($urandom_range(1)), AW'($urandom), TW'($urandom), be);
  endfunction

  task automatic idle_inputs();
    up_req_valid = 0; up_req_rw = 0; up_req_byteen = '0; up_req_addr = '0;
    up_req_data = '0; up_req_tag = '0; up_rsp_ready = 0; dn_req_ready = 0;
    dn_rsp_valid = 0; dn_rsp_data = '0;
  endtask

  task automatic clear_model();
    stim_q.delete(); req_q.delete(); rsp_q.delete();
    inflight = 0; resp_pending = 0; partial_exp = 0; delay = 0;
  endtask

  task automatic chk_rst_vals(input string pfx);
    chk({pfx, "_up_req_ready"}, up_req_ready, 1'b1);
    chk({pfx, "_dn_req_valid"}, dn_req_valid, 1'b0);
    chk({pfx, "_dn_rsp_ready"}, dn_rsp_ready, 1'b0);
    chk({pfx, "_up_rsp_valid"}, up_rsp_valid, 1'b0);
    chk({pfx, "_up_rsp_data"},  up_rsp_data,  '0);
    chk({pfx, "_up_rsp_tag"},   up_rsp_tag,   '0);
    chk({pfx, "_partial_wr"},   partial_wr,   1'b0);
    chk({pfx, "_busy"},         busy,         1'b0);
  endtask

  // One clock: check outputs against the model, drive inputs for the next edge, advance the model.
  task automatic cycle();
    bit dn_hs, rsp_hs, up_hs, push;
    logic [DW-1:0] rdata;
    req_t r;
    @(negedge clk);
    chk("up_req_ready", up_req_ready, req_q.size() < DEPTH);
    chk("dn_req_valid", dn_req_valid, req_q.size() > 0 && !inflight);
    chk("dn_rsp_ready", dn_rsp_ready, inflight && !resp_pending);
    chk("up_rsp_valid", up_rsp_valid, resp_pending);
    chk("busy",         busy,         req_q.size() > 0 || inflight);
    chk("partial_wr",   partial_wr,   partial_exp);
    if (dn_req_valid && req_q.size() > 0) begin
      chk("dn_req_rw",   dn_req_rw,   req_q[0].rw);
      chk("dn_req_addr", dn_req_addr, req_q[0].addr);
      chk("dn_req_data", dn_req_data, req_q[0].data);
    end
    if (up_rsp_valid && rsp_q.size() > 0) begin
      chk("up_rsp_data", up_rsp_data, rsp_q[0].data);
      chk("up_rsp_tag",  up_rsp_tag,  rsp_q[0].tag);
    end

    up_req_valid = (stim_q.size() > 0) && ($urandom_range(99) < p_req);
    if (up_req_valid) begin
      up_req_rw = stim_q[0].rw; up_req_byteen = stim_q[0].byteen; up_req_addr = stim_q[0].addr;
      up_req_data = stim_q[0].data; up_req_tag = stim_q[0].tag;
    end else begin
      up_req_rw = 1'($urandom); up_req_byteen = '0; up_req_addr = AW'($urandom);
      up_req_tag = TW'($urandom);
    end
    dn_req_ready = $urandom_range(99) < p_dnrdy;
    up_rsp_ready = $urandom_range(99) < p_rsprdy;
    rdata = use_fix_data ? fix_data : rand_line();
    if (inflight && !resp_pending) dn_rsp_valid = (delay == 0);
    else                           dn_rsp_valid = $urandom_range(99) < p_spur;
    dn_rsp_data = rdata;

    push   = up_req_valid && up_req_ready;
    dn_hs  = dn_req_valid && dn_req_ready;
    rsp_hs = dn_rsp_valid && dn_rsp_ready && inflight && !resp_pending;
    up_hs  = up_rsp_valid && up_rsp_ready && resp_pending;

    if (inflight && !resp_pending && delay > 0) delay--;
    if (up_hs) begin
      last_rsp_data = up_rsp_data; last_rsp_tag = up_rsp_tag;
      tag_log.push_back(up_rsp_tag);
      if (rsp_q.size() > 0) void'(rsp_q.pop_front());
      resp_pending = 0; inflight = 0; up_hs_cnt++;
    end
    if (rsp_hs) begin
      if (cur.rw) begin
        inflight = 0; wr_done_cnt++;
      end else begin
        rsp_t e;
        e.data = rdata; e.tag = cur.tag;
        rsp_q.push_back(e);
        resp_pending = 1;
      end
    end
    if (dn_hs && req_q.size() > 0) begin
      cur = req_q.pop_front();
      inflight = 1; dn_hs_cnt++;
      delay = (fix_delay >= 0) ? fix_delay : $urandom_range(4);
    end
    if (push) begin
      r = stim_q.pop_front();
      req_q.push_back(r);
      if (r.rw && r.byteen != '1) partial_exp = 1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    bit done;
    p_req = 80; p_dnrdy = 70; p_rsprdy = 70;
    n = 0;
    done = 0;
    while (!done && n < 3000) begin
      cycle();
      n++;
      done = stim_q.size() == 0 && req_q.size() == 0 && !inflight;
    end
    chk({tag, "_drained"}, done, 1'b1);
  endtask

  task automatic set_knobs(input int pr, input int pd, input int pu, input int ps, input int fd);
    p_req = pr; p_dnrdy = pd; p_rsprdy = pu; p_spur = ps; fix_delay = fd;
  endtask

  initial begin
    int base_dn, base_up, base_wr, n;
    n_chk = 0; n_bad = 0; dn_hs_cnt = 0; up_hs_cnt = 0; wr_done_cnt = 0;
    use_fix_data = 0; fix_data = {16{32'hDEADBEEF}};
    last_rsp_data = '0; last_rsp_tag = '0;
    clear_model();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    chk_rst_vals("por");
    reset = 1'b1;

    // Single read with a fixed 3-cycle adapter turnaround.
    set_knobs(100, 100, 100, 0, 2);
    use_fix_data = 1;
    base_dn = dn_hs_cnt; base_up = up_hs_cnt;
    stim_q.push_back(mk_req(1'b0, 26'h000100, 8'h2A, '1));
    repeat (12) cycle();
    chk("rd_dn_count", dn_hs_cnt - base_dn, 1);
    chk("rd_up_count", up_hs_cnt - base_up, 1);
    chk("rd_tag", last_rsp_tag, 8'h2A);
    chk("rd_data", last_rsp_data, fix_data);
    use_fix_data = 0;

    // Single full write: completion swallowed, no upstream response.
    base_up = up_hs_cnt; base_wr = wr_done_cnt;
    stim_q.push_back(mk_req(1'b1, 26'h000200, 8'h05, '1));
    repeat (12) cycle();
    chk("wr_done_count", wr_done_cnt - base_wr, 1);
    chk("wr_no_rsp", up_hs_cnt - base_up, 0);
    chk("wr_partial", partial_wr, 1'b0);

    // Fill with the adapter stalled, then release and expect in-order responses.
    set_knobs(100, 0, 100, 10, -1);
    tag_log.delete();
    for (int i = 1; i <= 5; i++) stim_q.push_back(mk_req(1'b0, AW'(i * 16), TW'(i), '1));
    repeat (8) cycle();
    chk("fill_ready", up_req_ready, 1'b0);
    chk("fill_left", stim_q.size(), 1);
    drain("fill");
    chk("fill_rsp_count", tag_log.size(), 5);
    for (int i = 0; i < 5 && i < tag_log.size(); i++) chk("fill_order", tag_log[i], TW'(i + 1));

    // Response backpressure: data/tag held, no further issue until the handshake.
    set_knobs(100, 100, 0, 20, 1);
    stim_q.push_back(mk_req(1'b0, 26'h3, 8'h33, '1));
    stim_q.push_back(mk_req(1'b0, 26'h4, 8'h34, '1));
    n = 0;
    while (!resp_pending && n < 50) begin cycle(); n++; end
    chk("bp_reached", resp_pending, 1'b1);
    repeat (6) cycle();
    chk("bp_hold_valid", up_rsp_valid, 1'b1);
    chk("bp_hold_tag", up_rsp_tag, 8'h33);
    chk("bp_no_issue", dn_req_valid, 1'b0);
    drain("bp");

    // Partial write sets the sticky flag, which survives random traffic.
    set_knobs(100, 100, 100, 10, -1);
    stim_q.push_back(mk_req(1'b1, 26'h10, 8'h44, {8'h00, {(BW-8){1'b1}}}));
    repeat (6) cycle();
    chk("pw_set", partial_wr, 1'b1);
    for (int i = 0; i < 300; i++) stim_q.push_back(rand_req());
    set_knobs(60, 50, 50, 20, -1);
    repeat (600) cycle();
    drain("rand");
    chk("pw_sticky", partial_wr, 1'b1);

    // Reset while waiting on the adapter with two entries queued.
    set_knobs(100, 100, 100, 0, 100);
    for (int i = 0; i < 3; i++) stim_q.push_back(mk_req(1'b0, AW'(i), TW'(8'h60 + i), '1));
    repeat (6) cycle();
    chk("mf_busy", busy, 1'b1);
    chk("mf_waiting", dn_rsp_ready, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_rst_vals("mf");
    idle_inputs();
    clear_model();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 150; i++) stim_q.push_back(rand_req());
    set_knobs(70, 60, 60, 20, -1);
    repeat (300) cycle();
    drain("post");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_ahb_req_queue.md
Name: vx_ahb_req_queue

Overview:
- Sits directly upstream of the Vortex-to-AHB adapter, between the Vortex memory request/response ports and the adapter.
- Buffers up to DEPTH Vortex requests and issues them one at a time, since the adapter handles a single outstanding 512-bit transfer and ignores tags.
- Keeps the tag of the in-flight request and returns it with the read response.
- Drops the adapter's completion for writes, because Vortex expects no write response.

Parameters:
- DATA_WIDTH, 512, line width in bits
- ADDR_WIDTH, 26, line address width (DATA_WIDTH/8-byte granule)
- TAG_WIDTH, 8, Vortex request tag width
- BYTEEN_WIDTH, DATA_WIDTH/8, byte-enable width
- DEPTH, 4, request FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- up_req_valid  in  1  Vortex request valid
- up_req_rw  in  1  1 = write
- up_req_byteen  in  BYTEEN_WIDTH  byte enables
- up_req_addr  in  ADDR_WIDTH  line address
- up_req_data  in  DATA_WIDTH  write data
- up_req_tag  in  TAG_WIDTH  request tag
- up_req_ready  out  1  queue can accept
- up_rsp_valid  out  1  read response valid
- up_rsp_data  out  DATA_WIDTH  read data
- up_rsp_tag  out  TAG_WIDTH  tag of the answered read
- up_rsp_ready  in  1  Vortex accepts response
- dn_req_valid  out  1  request to adapter
- dn_req_rw  out  1  to adapter
- dn_req_addr  out  ADDR_WIDTH  to adapter
- dn_req_data  out  DATA_WIDTH  to adapter
- dn_req_ready  in  1  adapter idle/accepting
- dn_rsp_valid  in  1  adapter transfer complete
- dn_rsp_data  in  DATA_WIDTH  adapter read data
- dn_rsp_ready  out  1  accept adapter completion
- partial_wr  out  1  sticky: a write with byteen not all-ones was accepted
- busy  out  1  FIFO non-empty or state not IDLE

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values:
  - FIFO empty, state IDLE.
  - All valid outputs 0, up_req_ready 1, partial_wr 0, busy 0.
  - up_rsp_data/up_rsp_tag 0.
- FIFO:
  - Push on up_req_valid && up_req_ready. up_req_ready = !full, derived from the registered count.
  - Entry holds {rw, addr, data, tag}. byteen is not stored.
  - Any accepted write with byteen != all-ones sets partial_wr; it clears only on reset. The full line is still written.
  - Pointers wrap modulo DEPTH. Count has $clog2(DEPTH)+1 bits.
  - Push and pop in the same cycle are both allowed. When full, push is blocked that cycle even if a pop occurs.
- Issue FSM, states IDLE, ISSUE, WAIT_RSP, RESP:
  - IDLE: FIFO non-empty -> ISSUE.
  - ISSUE:
    - dn_req_valid=1; dn_req_* driven from the FIFO head.
    - On dn_req_ready: pop, latch rw and tag into cur_rw/cur_tag, -> WAIT_RSP.
  - WAIT_RSP:
    - dn_rsp_ready=1.
    - On dn_rsp_valid with cur_rw=1 (write): discard; go to ISSUE if the FIFO is non-empty after this cycle, else IDLE.
    - On dn_rsp_valid with cur_rw=0 (read): register dn_rsp_data into up_rsp_data and cur_tag into up_rsp_tag, -> RESP.
  - RESP:
    - up_rsp_valid=1, data/tag stable.
    - On up_rsp_ready: go to ISSUE if the FIFO is non-empty, else IDLE.
- Ordering: strictly one outstanding downstream request. Responses return in request order.
- Latency:
  - Request pushed into an empty queue in cycle t -> dn_req_valid at t+1.
  - Read completion accepted in cycle k -> up_rsp_valid at k+1.
  - Back-to-back issue is possible the cycle after a write completion or a response handshake.
- Signal rules:
  - dn_req_valid, once asserted, stays high with stable payload until dn_req_ready.
  - dn_rsp_ready is 0 outside WAIT_RSP.
  - up_rsp_valid is 0 outside RESP.
  - dn_rsp_valid outside WAIT_RSP is ignored.
- Reset mid-transfer returns everything to reset values immediately. Queued requests are lost; the adapter is reset by the same signal.

Decomposition:
- Shared package vx_ahb_pkg:
  - typedef of the issue-state enum.
  - packed struct req_entry_t {rw, addr, data, tag}.
  - localparam for line size in bytes (64).
- Natural sub-module: vx_ahb_req_fifo, a parameterised synchronous FIFO of req_entry_t with push/pop/full/empty/count.
- FSM and response register stay in the top level.

Test Plan:
- Single read: addr 0x000100, tag 0x2A, adapter asserts dn_rsp_valid 3 cycles after accept with data 0xDEAD.. -> up_rsp_valid one cycle later, tag 0x2A, data 0xDEAD..; dn_req_valid pulses once.
- Single write, byteen all-ones, tag 0x05 -> one dn_req with rw=1 and matching data; completion consumed; up_rsp_valid never asserts; partial_wr stays 0.
- Fill: 5 reads with DEPTH=4 and dn_req_ready held 0 -> up_req_ready falls after the 4th push. Then release -> issued in order tags 1,2,3,4,5, responses in the same order.
- Backpressure: read completes while up_rsp_ready=0 for 6 cycles -> up_rsp_valid/data/tag stable for 6 cycles; next dn_req_valid only after the response handshake.
- Partial write: byteen 0x00FF..FF -> partial_wr rises the cycle after accept and stays 1 through subsequent traffic.
- Reset mid-flight: assert reset in WAIT_RSP with 2 entries queued -> all outputs return to reset values asynchronously; busy=0, up_req_ready=1 after release.
